// File: rtl/seven_seg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver: one digit lit per refresh slot,
// hex glyphs, leading-zero suppression, live blank mask, and frame-aligned value commits.
module seven_seg_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 50000,
  parameter int CNT_W       = 16
) (
  input  logic                    Clk,
  input  logic                    Rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] value,
  input  logic                    lz_suppress,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  output logic [6:0]              seg_out,
  output logic [NUM_DIGITS-1:0]   an_out,
  output logic                    committed,
  output logic                    frame_done
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  logic [CNT_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] disp_q, disp_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic                    pend_q, pend_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    commit_q, commit_d;
  logic                    fdone_q, fdone_d;
  logic                    boundary;
  logic                    blank;

  function automatic logic [6:0] glyph(input logic [3:0] nib);
    case (nib)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h18;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    boundary = (presc_q == PRESC_LAST) && (idx_q == IDX_LAST);

    presc_d = (presc_q == PRESC_LAST) ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (presc_q == PRESC_LAST) idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    shadow_d = shadow_q;
    pend_d   = pend_q;
    disp_d   = disp_q;
    commit_d = 1'b0;
    if (load) begin
      shadow_d = value;
      pend_d   = 1'b1;
    end
    // A load landing on the boundary bypasses the shadow and commits straight away
    if (boundary) begin
      if (load) begin
        disp_d   = value;
        pend_d   = 1'b0;
        commit_d = 1'b1;
      end else if (pend_q) begin
        disp_d   = shadow_q;
        pend_d   = 1'b0;
        commit_d = 1'b1;
      end
    end

    fdone_d = (presc_d == PRESC_LAST) && (idx_d == IDX_LAST);

    seg_d = 7'h7F;
    an_d  = '1;
    blank = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (idx_q == IDX_W'(k)) begin
        an_d[k] = 1'b0;
        blank   = blank_mask[k] || (lz_suppress && (k > 0) && ((disp_q >> (4*k)) == '0));
        seg_d   = blank ? 7'h7F : glyph(disp_q[4*k +: 4]);
      end
    end
  end

  // Output stage: registered view of the digit selected this cycle
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      presc_q  <= '0;
      idx_q    <= '0;
      disp_q   <= '0;
      shadow_q <= '0;
      pend_q   <= 1'b0;
      seg_q    <= 7'h7F;
      an_q     <= '1;
      commit_q <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      disp_q   <= disp_d;
      shadow_q <= shadow_d;
      pend_q   <= pend_d;
      seg_q    <= seg_d;
      an_q     <= an_d;
      commit_q <= commit_d;
      fdone_q  <= fdone_d;
    end
  end

  assign seg_out    = seg_q;
  assign an_out     = an_q;
  assign committed  = commit_q;
  assign frame_done = fdone_q;

endmodule

// File: doc/seven_seg_scan_driver.md
Name: seven_seg_scan_driver

Overview:
- Time-multiplexed driver for an NUM_DIGITS-wide common-anode seven-segment display.
- Holds a hex display value and scans one digit per refresh slot, using the team's standard hex glyph table.
- Supports leading-zero suppression, a per-digit blank mask, and tear-free updates: new values commit only at frame boundaries.
- Sits between the pattern-match result/counter logic and the board display pins.

Parameters:
- NUM_DIGITS, 4: number of digits scanned (2..8).
- REFRESH_DIV, 50000: clock cycles each digit stays lit (>=2).
- CNT_W, 16: prescaler width; must satisfy 2^CNT_W >= REFRESH_DIV.

Ports:
- Clk  in  1  system clock, rising edge.
- Rst  in  1  synchronous reset, active-low.
- load  in  1  single-cycle strobe; captures `value`.
- value  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 is LS.
- lz_suppress  in  1  1 = blank leading zero digits.
- blank_mask  in  NUM_DIGITS  bit k = 1 forces digit k blank; applied live.
- seg_out  out  7  segments g..a (bit6=g, bit0=a), active-low.
- an_out  out  NUM_DIGITS  anode enables, active-low, one-hot-cold.
- committed  out  1  one-cycle pulse when a pending value becomes displayed.
- frame_done  out  1  one-cycle pulse on the last cycle of digit NUM_DIGITS-1.

Behaviour:
- All state and outputs are registered. Reset applies on any Clk edge with Rst=0 and takes priority over everything.
- Reset values:
  - prescaler = 0, digit index = 0, display register = 0, shadow register = 0, pending = 0.
  - seg_out = 7'h7F; an_out = all 1s.
  - committed = 0; frame_done = 0.
- Prescaler:
  - Counts 0..REFRESH_DIV-1.
  - At REFRESH_DIV-1 it wraps to 0 and the digit index increments; index NUM_DIGITS-1 wraps to 0.
- Frame boundary is the cycle where the prescaler is REFRESH_DIV-1 and the index is NUM_DIGITS-1. On that cycle:
  - frame_done asserts on the registered output in the same cycle as that state; it is decoded one cycle early internally.
  - If pending=1, the display register takes the shadow register, pending clears, and committed pulses on the next cycle.
- Load:
  - load=1 writes `value` to the shadow register and sets pending.
  - A repeated load before commit overwrites the shadow register; last value wins and only one committed pulse is issued.
  - If load coincides with the frame boundary, the incoming `value` commits directly on that boundary and pending ends at 0.
- Output registers, each cycle, for the current index k:
  - an_out = ~(1<<k).
  - seg_out = glyph(display nibble k), or 7'h7F if digit k is blanked.
- Glyph table (active-low hex):
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:18, A:08, b:03, C:46, d:21, E:06, F:0E
- Digit k is blanked if either holds:
  - blank_mask[k]=1.
  - lz_suppress=1, k>0, and every display nibble from k up to NUM_DIGITS-1 is 0.
  - Digit 0 is never suppressed by lz_suppress, so value 0 shows a single "0".
- Latency:
  - After the first clock with Rst=1, the output cycle shows digit 0 with seg_out=7'h40 and an_out=~1.
  - Digit changes appear on outputs one cycle after the index advances.
- Reset mid-frame discards any pending value; there is no commit and no committed pulse.
- Anode guarantees: an_out never has more than one low bit, and is all-high only during and immediately after reset.

Test Plan (NUM_DIGITS=4, REFRESH_DIV=4):
- Reset release:
  - Stimulus: hold Rst=0 for 3 cycles, then release.
  - Required: during reset seg_out=7F, an_out=F.
  - Required: 1 cycle after release seg_out=40, an_out=E; an_out steps E,D,B,7 every 4 cycles.
  - Required: frame_done pulses every 16 cycles.
- Tear-free commit:
  - Stimulus: load value=16'h12AF at mid-frame (index 1).
  - Required: the displayed glyphs stay 0 until the frame boundary, then committed pulses once.
  - Required: the next frame shows digit0=0E, digit1=08, digit2=24, digit3=79.
- Overwrite and coincident load:
  - Stimulus: load 16'h1111, then 16'h2222 within the same frame.
  - Required: one committed pulse; 2222 is displayed.
  - Stimulus: load 16'h3333 exactly on a frame_done cycle.
  - Required: 3333 is displayed from the next frame; pending=0 with no extra committed pulse.
- Leading-zero suppression:
  - Stimulus: value=16'h0050, lz_suppress=1.
  - Required: digits 3 and 2 show 7F, digit1=12, digit0=40.
  - Stimulus: value=0.
  - Required: only digit 0 shows 40.
  - Stimulus: lz_suppress=0.
  - Required: all digits show glyphs.
- Blank mask:
  - Stimulus: blank_mask=4'b0101 with value=16'h8888.
  - Required: digits 0 and 2 show 7F, digits 1 and 3 show 00; the change takes effect within the current frame.
- Reset mid-operation:
  - Stimulus: load 16'hBEEF, then assert Rst before the boundary.
  - Required: no committed pulse; after release the display shows 0.
